idct_mac_unit: RTL and testbench

Multiply-accumulate unit for the inverse DCT in the JPEG decoder path. It mirrors the forward-DCT MAC unit used in `jpeg_encoder.fdct_zigzag.dct_mod` and runs in the opposite direction. It consumes `N_TERMS` dequantized coefficients, each paired with a cosine weight, and sums their products. It then rounds, level-shifts (optional) and saturates the sum into one 8-bit spatial sample. Eight instances form one row/column stage of the IDCT block; samples go downstream over a valid/ready handshake.

---
 rtl/idct_pkg.sv | 25 ++
 rtl/idct_round_sat.sv | 45 ++++
 rtl/idct_mac_unit.sv | 116 +++++++++++
 tb/tb_idct_mac_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared types and default widths for the IDCT multiply-accumulate unit.
// The level-shift option is selected by the IDCT_MAC_LEVEL_SHIFT_EN macro in idct_round_sat.
package idct_pkg;

   localparam int unsigned IDCT_DATA_W  = 12;
   localparam int unsigned IDCT_COEF_W  = 12;
   localparam int unsigned IDCT_FRAC_W  = 11;
   localparam int unsigned IDCT_N_TERMS = 8;
   localparam int unsigned IDCT_OUT_W   = 8;

   // Mid-scale offset that turns a signed sample into an unsigned pixel.
   function automatic int level_offset(input int unsigned out_w);
      return 1 << (out_w - 1);
   endfunction

   localparam int IDCT_LEVEL_OFFSET = level_offset(IDCT_OUT_W);

   typedef enum logic [1:0] {
      StAccum,
      StDrain1,
      StDrain2,
      StOut
   } idct_mac_state_t;

endpackage

// File: rtl/idct_round_sat.sv
// Combinational round-half-up, optional level shift and clamp of the accumulator.
// IDCT_MAC_LEVEL_SHIFT_EN: add mid-scale offset and clamp to unsigned range.
module idct_round_sat
   import idct_pkg::*;
#(
   parameter int unsigned ACC_W  = 27,
   parameter int unsigned FRAC_W = IDCT_FRAC_W,
   parameter int unsigned OUT_W  = IDCT_OUT_W
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic        [OUT_W-1:0] sample
);

   // Two guard bits keep the rounding bias and offset from overflowing.
   localparam int unsigned SUM_W = ACC_W + 2;
   localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1) << (FRAC_W - 1);

`ifdef IDCT_MAC_LEVEL_SHIFT_EN
   localparam logic signed [SUM_W-1:0] OFFSET = SUM_W'(level_offset(OUT_W));
   localparam logic signed [SUM_W-1:0] LO     = '0;
   localparam logic signed [SUM_W-1:0] HI     = (SUM_W'(1) << OUT_W) - SUM_W'(1);
`else
   localparam logic signed [SUM_W-1:0] OFFSET = '0;
   localparam logic signed [SUM_W-1:0] LO     = -(SUM_W'(1) << (OUT_W - 1));
   localparam logic signed [SUM_W-1:0] HI     = (SUM_W'(1) << (OUT_W - 1)) - SUM_W'(1);
`endif

   logic signed [SUM_W-1:0] acc_ext;
   logic signed [SUM_W-1:0] rounded;
   logic signed [SUM_W-1:0] shifted;

   always_comb begin
      acc_ext = {{2{acc[ACC_W-1]}}, acc};
      rounded = (acc_ext + HALF) >>> FRAC_W;
      shifted = rounded + OFFSET;
      if (shifted < LO) begin
         sample = LO[OUT_W-1:0];
      end else if (shifted > HI) begin
         sample = HI[OUT_W-1:0];
      end else begin
         sample = shifted[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/idct_mac_unit.sv
// IDCT multiply-accumulate: sums N_TERMS products, then rounds and saturates to one sample.
// IDCT_MAC_LEVEL_SHIFT_EN (in idct_round_sat) selects unsigned level-shifted output.
module idct_mac_unit
   import idct_pkg::*;
#(
   parameter int unsigned DATA_W  = IDCT_DATA_W,
   parameter int unsigned COEF_W  = IDCT_COEF_W,
   parameter int unsigned FRAC_W  = IDCT_FRAC_W,
   parameter int unsigned N_TERMS = IDCT_N_TERMS,
   parameter int unsigned OUT_W   = IDCT_OUT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic signed [COEF_W-1:0] in_coef,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic        [OUT_W-1:0]  out_data
);

   localparam int unsigned PROD_W = DATA_W + COEF_W;
   localparam int unsigned ACC_W  = PROD_W + $clog2(N_TERMS);
   localparam int unsigned CNT_W  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

   idct_mac_state_t          state_q, state_d;
   logic [CNT_W-1:0]         term_cnt_q, term_cnt_d;
   logic signed [PROD_W-1:0] prod_q, prod_d;
   logic                     prod_vld_q, prod_vld_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic                     out_valid_q, out_valid_d;
   logic [OUT_W-1:0]         out_data_q, out_data_d;
   logic [OUT_W-1:0]         sat_data;
   logic                     accept;

   assign in_ready  = (state_q == StAccum) && !rst;
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   idct_round_sat #(
      .ACC_W  (ACC_W),
      .FRAC_W (FRAC_W),
      .OUT_W  (OUT_W)
   ) u_round_sat (
      .acc    (acc_q),
      .sample (sat_data)
   );

   always_comb begin
      state_d     = state_q;
      term_cnt_d  = term_cnt_q;
      prod_d      = prod_q;
      prod_vld_d  = accept;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      // Product is registered one cycle ahead of its accumulation.
      if (prod_vld_q) begin
         acc_d = acc_q + ACC_W'(prod_q);
      end

      if (accept) begin
         prod_d     = PROD_W'(in_data) * PROD_W'(in_coef);
         term_cnt_d = (term_cnt_q == LAST_TERM) ? '0 : term_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         StAccum: begin
            if (accept && (term_cnt_q == LAST_TERM)) begin
               state_d = StDrain1;
            end
         end
         StDrain1: begin
            state_d = StDrain2;
         end
         StDrain2: begin
            out_data_d  = sat_data;
            out_valid_d = 1'b1;
            state_d     = StOut;
         end
         StOut: begin
            if (out_valid_q && out_ready) begin
               acc_d       = '0;
               out_valid_d = 1'b0;
               state_d     = StAccum;
            end
         end
         default: state_d = StAccum;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StAccum;
         term_cnt_q  <= '0;
         prod_q      <= '0;
         prod_vld_q  <= 1'b0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         term_cnt_q  <= term_cnt_d;
         prod_q      <= prod_d;
         prod_vld_q  <= prod_vld_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

endmodule

// File: tb/tb_idct_mac_unit.sv
// Directed scoreboard bench for idct_mac_unit; honours IDCT_MAC_LEVEL_SHIFT_EN.
module tb_idct_mac_unit;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic signed [11:0] in_data;
   logic signed [11:0] in_coef;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        out_data;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         last_t = 0;
   int         dd[8];
   int         cc[8];
   logic [7:0] exp_q[$];

   idct_mac_unit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_coef   (in_coef),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   function automatic logic [7:0] pick(input int s, input int u);
`ifdef IDCT_MAC_LEVEL_SHIFT_EN
      return 8'(u);
`else
      return 8'(s);
`endif
   endfunction

   function automatic logic [7:0] model(input longint acc);
      longint r;
      r = (acc + 64'sd1024) >>> 11;
`ifdef IDCT_MAC_LEVEL_SHIFT_EN
      r = r + 128;
      if (r < 0) r = 0;
      if (r > 255) r = 255;
`else
      if (r < -128) r = -128;
      if (r > 127) r = 127;
`endif
      return r[7:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge; returns one negedge after the accepting edge.
   task automatic send_term(input int d, input int c);
      int n;
      in_valid = 1'b1;
      in_data  = 12'(d);
      in_coef  = 12'(c);
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_timeout", {31'd0, in_ready}, 32'd1);
      last_t = cyc;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_block(input int gap);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) repeat (gap) @(negedge clk);
         send_term(dd[i], cc[i]);
      end
   endtask

   task automatic wait_out(input string tag);
      int n;
      logic [7:0] e;
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_latency"}, cyc, last_t + 3);
      if (exp_q.size() == 0) begin
         e = 8'hxx;
      end else begin
         e = exp_q.pop_front();
      end
      check({tag, "_data"}, {24'd0, out_data}, {24'd0, e});
   endtask

   task automatic after_handshake(input string tag);
      @(negedge clk);
      check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_ready_rise"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic set_dc();
      for (int i = 0; i < 8; i++) begin
         dd[i] = 0;
         cc[i] = 1024;
      end
      dd[0] = 64;
   endtask

   initial begin
      longint sum;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      in_coef = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      set_dc();
      exp_q.push_back(pick(32, 160));
      send_block(0);
      wait_out("dc");
      after_handshake("dc");

      set_dc();
      dd[0] = 3;
      exp_q.push_back(pick(2, 130));
      send_block(0);
      wait_out("round_pos");
      after_handshake("round_pos");

      dd[0] = -3;
      exp_q.push_back(pick(-1, 127));
      send_block(0);
      wait_out("round_neg");
      after_handshake("round_neg");

      for (int i = 0; i < 8; i++) begin
         dd[i] = 2047;
         cc[i] = 2047;
      end
      exp_q.push_back(pick(127, 255));
      send_block(0);
      wait_out("sat_pos");
      after_handshake("sat_pos");

      for (int i = 0; i < 8; i++) dd[i] = -2048;
      exp_q.push_back(pick(-128, 0));
      send_block(0);
      wait_out("sat_neg");
      after_handshake("sat_neg");

      // Backpressure; a term offered while stalled must be ignored.
      out_ready = 1'b0;
      set_dc();
      exp_q.push_back(pick(32, 160));
      send_block(0);
      wait_out("bp");
      in_valid = 1'b1;
      in_data  = 12'sd64;
      in_coef  = 12'sd1024;
      repeat (5) begin
         @(negedge clk);
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_hold_data", {24'd0, out_data}, {24'd0, pick(32, 160)});
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      after_handshake("bp");

      for (int i = 0; i < 8; i++) dd[i] = 0;
      exp_q.push_back(pick(0, 128));
      send_block(0);
      wait_out("acc_clear");
      after_handshake("acc_clear");

      set_dc();
      exp_q.push_back(pick(32, 160));
      send_block(2);
      wait_out("bubble");
      after_handshake("bubble");

      // Abort a block halfway; its partial sum must not leak into the next one.
      for (int i = 0; i < 4; i++) send_term(64, 1024);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_ready_back", {31'd0, in_ready}, 32'd1);
      set_dc();
      exp_q.push_back(pick(32, 160));
      send_block(0);
      wait_out("after_abort");
      after_handshake("after_abort");

      out_ready = 1'b0;
      exp_q.push_back(pick(32, 160));
      send_block(0);
      wait_out("rst_out");
      rst = 1'b1;
      @(negedge clk);
      check("rst_out_valid_drop", {31'd0, out_valid}, 32'd0);
      check("rst_out_data_clear", {24'd0, out_data}, 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);

      for (int b = 0; b < 3; b++) begin
         sum = 0;
         for (int i = 0; i < 8; i++) begin
            dd[i] = int'($urandom_range(0, 4095)) - 2048;
            cc[i] = int'($urandom_range(0, 4095)) - 2048;
            sum = sum + longint'(dd[i]) * longint'(cc[i]);
         end
         exp_q.push_back(model(sum));
         send_block(b);
         wait_out("random");
         after_handshake("random");
      end

      check("sb_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
